// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: state encoding and parity-mode constants shared by fifo_uart_tx
package fifo_uart_pkg;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP} tx_state_t;
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;
endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO read port plus serial-line status of fifo_uart_tx
//   fifo_empty, fifo_rd_data : from the FIFO (registered read)
//   fifo_rd_en               : single-cycle pop strobe to the FIFO
//   tx, busy, frame_done     : serial line and frame status
interface fifo_uart_tx_if #(parameter int DATA_BITS = 8);
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 fifo_rd_en;
    logic                 tx;
    logic                 busy;
    logic                 frame_done;
    modport master (output fifo_empty, fifo_rd_data, input fifo_rd_en, tx, busy, frame_done);
    modport slave  (input fifo_empty, fifo_rd_data, output fifo_rd_en, tx, busy, frame_done);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter with enable and synchronous clear
//   clk, reset : clock, synchronous active-high reset
//   clk_en     : counter advances only when high
//   clear      : restart the bit period at 0
//   bit_tick   : high on the last cycle of a bit period
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_en,
    input  logic clear,
    output logic bit_tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic [CW-1:0] cnt;
    assign bit_tick = cnt == CW'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk)
        if (reset) cnt <= '0;
        else if (clk_en) cnt <= (clear || bit_tick) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a synchronous FIFO and sends them as UART frames
//   clk, reset, clk_en : clock, synchronous active-high reset, global enable
//   bus (slave)        : fifo_empty/fifo_rd_data in, fifo_rd_en/tx/busy/frame_done out
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1,
    parameter int PARITY       = 0
) (
    input logic           clk,
    input logic           reset,
    input logic           clk_en,
    fifo_uart_tx_if.slave bus
);
    localparam int BW = $clog2(DATA_BITS + 1);
    tx_state_t            state, state_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic [BW-1:0]        bit_idx, bit_n;
    logic                 par, par_n, tx_q, tx_n, tick, last_stop;
    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk(clk),
        .reset(reset),
        .clk_en(clk_en),
        .clear(state_n != state),
        .bit_tick(tick)
    );
    assign last_stop      = state == S_STOP && tick && bit_idx == BW'(STOP_BITS - 1);
    assign bus.fifo_rd_en = clk_en && state == S_FETCH && !bus.fifo_empty;
    assign bus.busy       = state != S_IDLE;
    assign bus.frame_done = clk_en && last_stop;
    assign bus.tx         = tx_q;
    always_comb begin
        state_n = state;
        sh_n    = sh;
        bit_n   = bit_idx;
        par_n   = par;
        case (state)
            S_IDLE:   state_n = bus.fifo_empty ? S_IDLE : S_FETCH;
            S_FETCH:  state_n = S_LOAD;
            S_LOAD: begin
                sh_n    = bus.fifo_rd_data;
                par_n   = PARITY == PAR_EVEN ? ^bus.fifo_rd_data : ~^bus.fifo_rd_data;
                state_n = S_START;
            end
            S_START:  state_n = tick ? S_DATA : S_START;
            S_DATA:
                if (tick) begin
                    sh_n  = sh >> 1;
                    bit_n = bit_idx + BW'(1);
                    if (bit_idx == BW'(DATA_BITS - 1)) state_n = PARITY != PAR_NONE ? S_PARITY : S_STOP;
                end
            S_PARITY: state_n = tick ? S_STOP : S_PARITY;
            S_STOP:
                if (last_stop) state_n = bus.fifo_empty ? S_IDLE : S_FETCH;
                else if (tick) bit_n = bit_idx + BW'(1);
            default:  state_n = S_IDLE;
        endcase
        if (state_n != state) bit_n = '0;
        // tx is registered from the next state so the line changes on the state-entry edge
        tx_n = state_n == S_START ? 1'b0 : state_n == S_DATA ? sh_n[0] : state_n == S_PARITY ? par_n : 1'b1;
    end
    always_ff @(posedge clk)
        if (reset) begin
            state   <= S_IDLE;
            sh      <= '0;
            bit_idx <= '0;
            par     <= 1'b0;
            tx_q    <= 1'b1;
        end else if (clk_en) begin
            state   <= state_n;
            sh      <= sh_n;
            bit_idx <= bit_n;
            par     <= par_n;
            tx_q    <= tx_n;
        end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: checks three fifo_uart_tx configurations against a frame-level model
module tb_fifo_uart_tx;
    localparam int CPB = 4;
    localparam int NL  = 200;
    logic clk = 1'b0, reset = 1'b1, clk_en = 1'b1;
    always #5 clk = ~clk;
    int checks = 0, errors = 0;
    logic [7:0] mem [3][32];
    int wp [3], rp [3], mrp [3];
    logic [7:0] rdd [3];
    logic [2:0] emp_v, tx_v, busy_v, rd_v, fd_v;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int PAR = g;
        localparam int STP = g == 2 ? 2 : 1;
        fifo_uart_tx_if #(.DATA_BITS(8)) bus ();
        fifo_uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(STP), .PARITY(PAR)) dut (
            .clk(clk),
            .reset(reset),
            .clk_en(clk_en),
            .bus(bus)
        );
        assign emp_v[g]         = wp[g] == rp[g];
        assign bus.fifo_empty   = emp_v[g];
        assign bus.fifo_rd_data = rdd[g];
        assign tx_v[g]          = bus.tx;
        assign busy_v[g]        = bus.busy;
        assign rd_v[g]          = bus.fifo_rd_en;
        assign fd_v[g]          = bus.frame_done;
        always @(posedge clk)
            if (rd_v[g]) begin
                rdd[g] <= mem[g][rp[g]];
                rp[g]  <= rp[g] + 1;
            end
    end
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", n, $time, a, e);
        end
    endtask
    int par_of [3] = '{0, 1, 2};
    int stp_of [3] = '{1, 1, 2};
    bit act [3];
    int pos [3];
    logic [7:0] mb [3];
    function automatic int flen(input int i);
        return 2 + (9 + (par_of[i] != 0 ? 1 : 0) + stp_of[i]) * CPB;
    endfunction
    // {tx, busy, rd_en, frame_done} at cycle p of a frame (FETCH is p=0)
    function automatic logic [3:0] sched(input int i, input logic [7:0] b, input int p);
        int k;
        logic t;
        if (p < 2) return p == 0 ? 4'b1110 : 4'b1100;
        k = (p - 2) / CPB;
        if (k == 0) t = 1'b0;
        else if (k <= 8) t = b[k-1];
        else if (par_of[i] != 0 && k == 9) t = (^b) ^ (par_of[i] == 2);
        else t = 1'b1;
        return {t, 2'b10, p == flen(i) - 1};
    endfunction
    always @(posedge clk)
        for (int i = 0; i < 3; i++)
            if (reset) act[i] = 1'b0;
            else if (clk_en) begin
                if (act[i]) begin
                    pos[i] = pos[i] + 1;
                    if (pos[i] == flen(i)) act[i] = 1'b0;
                end
                if (!act[i] && wp[i] != mrp[i]) begin
                    act[i] = 1'b1;
                    pos[i] = 0;
                    mb[i]  = mem[i][mrp[i]];
                    mrp[i] = mrp[i] + 1;
                end
            end
    bit chk_on = 1'b0;
    logic [3:0] e_m;
    always @(negedge clk)
        if (chk_on)
            for (int i = 0; i < 3; i++) begin
                e_m = act[i] ? sched(i, mb[i], pos[i]) : 4'b1000;
                e_m[1] = e_m[1] & clk_en;
                e_m[0] = e_m[0] & clk_en;
                chk($sformatf("model%0d", i), {tx_v[i], busy_v[i], rd_v[i], fd_v[i]}, e_m);
            end
    bit tx_l [3][NL];
    bit fd_l [3][NL];
    bit rd_l [3][NL];
    bit bs_l [3][NL];
    task automatic push(input int i, input logic [7:0] v);
        mem[i][wp[i]] = v;
        wp[i] = wp[i] + 1;
    endtask
    task automatic capture(input int n, input int off_at, input int off_len, input int rst_at);
        for (int i = 0; i < 3; i++)
            for (int c = 0; c < NL; c++) begin
                tx_l[i][c] = 1'b1;
                fd_l[i][c] = 1'b0;
                rd_l[i][c] = 1'b0;
                bs_l[i][c] = 1'b0;
            end
        for (int c = 0; c < n; c++) begin
            clk_en = !(c >= off_at && c < off_at + off_len);
            reset  = c == rst_at;
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                tx_l[i][c] = tx_v[i];
                fd_l[i][c] = fd_v[i];
                rd_l[i][c] = rd_v[i];
                bs_l[i][c] = busy_v[i];
            end
            @(posedge clk);
            #1;
        end
        clk_en = 1'b1;
        reset  = 1'b0;
    endtask
    function automatic int find_tx0(input int i, input int from);
        for (int c = from; c < NL; c++) if (!tx_l[i][c]) return c;
        return -1;
    endfunction
    function automatic int find_fd(input int i, input int from);
        for (int c = from; c < NL; c++) if (fd_l[i][c]) return c;
        return -1;
    endfunction
    function automatic int count_rd(input int i, input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) n += rd_l[i][c] ? 1 : 0;
        return n;
    endfunction
    function automatic int count_tx(input int i, input int a, input int b, input bit v);
        int n = 0;
        if (a < 0) return -1;
        for (int c = a; c <= b && c < NL; c++) n += tx_l[i][c] == v ? 1 : 0;
        return n;
    endfunction
    function automatic logic [7:0] decode(input int i, input int s);
        logic [7:0] b;
        if (s < 0 || s + CPB * 9 >= NL) return 8'hxx;
        for (int k = 0; k < 8; k++) b[k] = tx_l[i][s + CPB * (k + 1) + CPB / 2];
        return b;
    endfunction
    function automatic logic [9:0] line_bits(input int i, input int s);
        logic [9:0] v;
        if (s < 0 || s + CPB * 10 >= NL) return 10'hxxx;
        for (int k = 0; k < 10; k++) v[k] = tx_l[i][s + CPB * k + CPB / 2];
        return v;
    endfunction
    int s1, s2, s3, f1, f2, f3;
    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_on = 1'b1;
        chk("reset_tx", tx_v, 3'b111);
        chk("reset_busy", busy_v, 3'b000);
        chk("reset_rd_en", rd_v, 3'b000);
        chk("reset_frame_done", fd_v, 3'b000);
        capture(100, -1, 0, -1);
        chk("idle_rd_pulses", count_rd(0, 0, 99) + count_rd(1, 0, 99) + count_rd(2, 0, 99), 0);
        chk("idle_tx_low_cycles", count_tx(0, 0, 99, 1'b0), 0);
        chk("idle_busy", bs_l[0][50] | bs_l[1][50] | bs_l[2][50], 0);
        push(0, 8'h0F);
        capture(60, -1, 0, -1);
        s1 = find_tx0(0, 0);
        f1 = find_fd(0, 0);
        chk("single_start_latency", s1, 3);
        chk("single_rd_pulses", count_rd(0, 0, 59), 1);
        chk("single_rd_cycle", rd_l[0][1], 1);
        chk("single_line_bits", line_bits(0, s1), 10'h21E);
        chk("single_frame_len", f1 - s1 + 1, 40);
        chk("single_fd_pulses", find_fd(0, f1 + 1), -1);
        push(0, 8'h0F);
        push(0, 8'h45);
        push(0, 8'h2A);
        capture(140, -1, 0, -1);
        s1 = find_tx0(0, 0);
        f1 = find_fd(0, 0);
        s2 = find_tx0(0, f1 + 1);
        f2 = find_fd(0, s2);
        s3 = find_tx0(0, f2 + 1);
        f3 = find_fd(0, s3);
        chk("b2b_rd_pulses", count_rd(0, 0, 139), 3);
        chk("b2b_byte0", decode(0, s1), 8'h0F);
        chk("b2b_byte1", decode(0, s2), 8'h45);
        chk("b2b_byte2", decode(0, s3), 8'h2A);
        chk("b2b_gap", s2 - f1 - 1, 2);
        chk("b2b_gap2", s3 - f2 - 1, 2);
        chk("b2b_last_fd", f3, 126);
        chk("b2b_idle_busy", bs_l[0][135], 0);
        push(1, 8'h45);
        push(2, 8'h45);
        capture(70, -1, 0, -1);
        s1 = find_tx0(1, 0);
        s2 = find_tx0(2, 0);
        chk("even_byte", decode(1, s1), 8'h45);
        chk("even_parity_bit", tx_l[1][s1 + 9 * CPB + CPB / 2], 1);
        chk("odd_parity_bit", tx_l[2][s2 + 9 * CPB + CPB / 2], 0);
        chk("even_frame_len", find_fd(1, 0) - s1 + 1, 44);
        chk("odd2stop_frame_len", find_fd(2, 0) - s2 + 1, 48);
        chk("two_stop_high", count_tx(2, s2 + 40, s2 + 47, 1'b1), 8);
        push(0, 8'h55);
        capture(70, 20, 7, -1);
        s1 = find_tx0(0, 0);
        chk("freeze_prev_bit", tx_l[0][18], 1);
        chk("freeze_bit3_len", count_tx(0, 19, 29, 1'b0), 11);
        chk("freeze_next_bit", tx_l[0][30], 1);
        chk("freeze_frame_len", find_fd(0, 0) - s1 + 1, 47);
        push(0, 8'hA5);
        push(0, 8'h3C);
        capture(80, -1, 0, 20);
        chk("rst_before_tx", tx_l[0][20], 0);
        chk("rst_after_tx", tx_l[0][21], 1);
        chk("rst_rd_before", count_rd(0, 0, 20), 1);
        chk("rst_rd_after", count_rd(0, 21, 79), 1);
        s2 = find_tx0(0, 21);
        chk("rst_restart", s2, 24);
        chk("rst_byte", decode(0, s2), 8'h3C);
        chk("rst_fd", find_fd(0, 0), 63);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
